// File: rtl/sdlc_tx_sched.sv
// Frame scheduler for one sdlc transmitter: round-robin grant between two sources,
// then length load, preamble/flag bytes, tx_drq-paced data words, end-of-frame wait and gap.
module sdlc_tx_sched #(
  parameter int LEN_W    = 4,
  parameter int FLAG_CNT = 3,
  parameter int GAP      = 8,
  parameter int TIMEOUT  = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [15:0]      rd_data0,
  input  logic [15:0]      rd_data1,
  output logic             word_rd,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic             err,
  output logic             busy,
  output logic             len_wr,
  output logic [7:0]       len_data,
  output logic             flag_wr,
  output logic [7:0]       flag_data,
  output logic             dat_wr,
  output logic [15:0]      dat_data,
  input  logic             tx_drq,
  input  logic             tx_done
);

  localparam int FCW = $clog2(FLAG_CNT + 2);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int GW  = $clog2(GAP + 2);
  localparam logic [FCW-1:0] FC_LAST  = FCW'(FLAG_CNT);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_LEN, S_FLAGS, S_DATA, S_WAIT_DONE, S_GAP
  } state_t;

  state_t           r_state, w_next;
  logic [1:0]       r_grant, r_done;
  logic             r_err, r_ptr, r_sel;
  logic [LEN_W-1:0] r_len, r_cnt;
  logic [FCW-1:0]   r_fcnt;
  logic [TW-1:0]    r_tmo;
  logic [GW-1:0]    r_gap;
  logic             w_any_req, w_pick, w_fin, w_abort;
  logic [7:0]       w_len_code;

  // r_ptr names the requester that wins when both are asking
  assign w_any_req  = |req;
  assign w_pick     = req[r_ptr] ? r_ptr : ~r_ptr;
  assign w_len_code = 8'({r_len, 4'd7});

  assign grant = r_grant;
  assign done  = r_done;
  assign err   = r_err;
  assign busy  = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_fin     = 1'b0;
    w_abort   = 1'b0;
    word_rd   = 1'b0;
    dat_wr    = 1'b0;
    dat_data  = '0;
    len_wr    = 1'b0;
    len_data  = '0;
    flag_wr   = 1'b0;
    flag_data = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_next = S_LOAD_LEN;
      end
      S_LOAD_LEN: begin
        if (r_len == '0) begin
          w_fin   = 1'b1;
          w_abort = 1'b1;
          w_next  = S_GAP;
        end else begin
          len_wr   = 1'b1;
          len_data = w_len_code;
          w_next   = S_FLAGS;
        end
      end
      S_FLAGS: begin
        flag_wr   = 1'b1;
        flag_data = (r_fcnt == FC_LAST) ? 8'h7E : 8'hFF;
        if (r_fcnt == FC_LAST) w_next = S_DATA;
      end
      S_DATA: begin
        // FWFT source: the word on rd_data is written and popped in the same cycle
        if (tx_drq) begin
          word_rd  = 1'b1;
          dat_wr   = 1'b1;
          dat_data = r_sel ? rd_data1 : rd_data0;
          if (r_cnt == LEN_W'(1)) w_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (tx_done) begin
          w_fin  = 1'b1;
          w_next = S_GAP;
        end else if (r_tmo == TMO_LAST) begin
          w_fin   = 1'b1;
          w_abort = 1'b1;
          w_next  = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_ptr   <= 1'b0;
      r_sel   <= 1'b0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_fcnt  <= '0;
      r_tmo   <= '0;
      r_gap   <= '0;
    end else begin
      r_done <= w_fin ? r_grant : 2'b00;
      r_err  <= w_abort;
      r_fcnt <= (r_state == S_FLAGS)     ? r_fcnt + 1'b1 : '0;
      r_tmo  <= (r_state == S_WAIT_DONE) ? r_tmo + 1'b1  : '0;
      r_gap  <= (r_state == S_GAP)       ? r_gap + 1'b1  : '0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel   <= w_pick;
            r_grant <= w_pick ? 2'b10 : 2'b01;
            r_ptr   <= ~w_pick;
            r_len   <= w_pick ? len1 : len0;
          end
        end
        S_LOAD_LEN: r_cnt <= r_len;
        S_DATA:     if (tx_drq) r_cnt <= r_cnt - 1'b1;
        // done is visible in the first GAP cycle; grant drops right after it
        S_GAP:      r_grant <= '0;
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdlc_tx_sched.sv
// Scoreboard bench for sdlc_tx_sched: directed frames push expected strobes,
// a negedge monitor pops and compares every len/flag/dat/done event.
module tb_sdlc_tx_sched;
  localparam int LEN_W = 4, FLAG_CNT = 3, GAP = 8, TIMEOUT = 4096;
  localparam logic [2:0] K_LEN = 3'd1, K_FLG = 3'd2, K_DAT = 3'd3, K_DONE = 3'd4;

  logic clk = 1'b0;
  logic reset, tx_drq, tx_done, src_clr;
  logic [1:0] req, grant, done;
  logic [LEN_W-1:0] len0, len1;
  logic [15:0] rd_data0, rd_data1, dat_data;
  logic word_rd, err, busy, len_wr, flag_wr, dat_wr;
  logic [7:0] len_data, flag_data;

  sdlc_tx_sched #(.LEN_W(LEN_W), .FLAG_CNT(FLAG_CNT), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .word_rd(word_rd), .grant(grant),
    .done(done), .err(err), .busy(busy), .len_wr(len_wr), .len_data(len_data),
    .flag_wr(flag_wr), .flag_data(flag_data), .dat_wr(dat_wr), .dat_data(dat_data),
    .tx_drq(tx_drq), .tx_done(tx_done));

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] kind; logic [15:0] data; } ev_t;
  ev_t exp_q[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  bit have_done = 1'b0;

  logic [15:0] mem0 [16];
  logic [15:0] mem1 [16];
  int rp0 = 0, rp1 = 0;
  assign rd_data0 = mem0[rp0[3:0]];
  assign rd_data1 = mem1[rp1[3:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (src_clr) begin
      rp0 <= 0;
      rp1 <= 0;
    end else begin
      if (word_rd && grant[0]) rp0 <= rp0 + 1;
      if (word_rd && grant[1]) rp1 <= rp1 + 1;
    end
  end

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  function automatic void push(logic [2:0] k, logic [15:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void sb(logic [2:0] k, logic [15:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got kind %0d data %h, expected nothing (cycle %0d)", k, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.data !== d) begin
        n_fail++;
        $display("FAIL sb_event: got kind %0d data %h, expected kind %0d data %h (cycle %0d)",
                 k, d, e.kind, e.data, cyc);
      end
    end
  endfunction

  // g: requester index; words come from that requester's memory starting at base
  function automatic void push_frame(int g, int n, int base, logic [7:0] code, logic err_exp);
    push(K_LEN, {8'h00, code});
    for (int i = 0; i < FLAG_CNT; i++) push(K_FLG, 16'h00FF);
    push(K_FLG, 16'h007E);
    for (int i = 0; i < n; i++) push(K_DAT, (g == 1) ? mem1[base + i] : mem0[base + i]);
    push(K_DONE, {13'd0, err_exp, (g == 1) ? 2'b10 : 2'b01});
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (len_wr)  sb(K_LEN, {8'h00, len_data});
      if (flag_wr) sb(K_FLG, {8'h00, flag_data});
      if (dat_wr) begin
        sb(K_DAT, dat_data);
        chk("dat_needs_drq", {31'd0, tx_drq}, 32'd1);
        chk("dat_with_rd", {31'd0, word_rd}, 32'd1);
      end
      if (len_wr || flag_wr || dat_wr)
        chk("one_strobe", 32'(len_wr) + 32'(flag_wr) + 32'(dat_wr), 32'd1);
      if (done != 2'b00) sb(K_DONE, {13'd0, err, done});
      else if (err) chk("err_without_done", {31'd0, err}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [1:0] g, input int n, input bit send_done, input int delay,
                           output int dat_first, output int dat_last, output int done_c);
    bit seen;
    int cnt;
    seen = 1'b0;
    dat_first = 0;
    dat_last = 0;
    done_c = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (len_wr) begin seen = 1'b1; break; end
    end
    chk("len_wr_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      chk("grant", {30'd0, grant}, {30'd0, g});
      if (have_done) begin
        n_checks++;
        if (cyc - last_done_cyc - 1 < GAP) begin
          n_fail++;
          $display("FAIL gap: got %0d idle cycles, required at least %0d", cyc - last_done_cyc - 1, GAP);
        end
      end
    end
    cnt = 0;
    for (int k = 0; k < 200 && cnt < n; k++) begin
      @(negedge clk);
      if (dat_wr) begin
        if (cnt == 0) dat_first = cyc;
        dat_last = cyc;
        cnt++;
      end
    end
    chk("dat_count", cnt, n);
    if (send_done) begin
      repeat (delay) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < TIMEOUT + 100; k++) begin
      @(negedge clk);
      if (done != 2'b00) begin seen = 1'b1; break; end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    done_c = cyc;
    last_done_cyc = cyc;
    have_done = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f, l, d, rc;
    bit seen;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    reset = 1'b1; req = 2'b00; len0 = '0; len1 = '0;
    tx_drq = 1'b0; tx_done = 1'b0; src_clr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 16'h0000;
      mem1[i] = 16'h0000;
    end
    repeat (3) tick();
    chk("reset_outputs", {22'd0, grant, done, err, busy, len_wr, flag_wr, dat_wr, word_rd}, 32'd0);
    src_clr = 1'b0;
    reset = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Arbitration: both requesting, expect 01,10,01
    mem0[0] = 16'hA0A0; mem0[1] = 16'hA1A1; mem0[2] = 16'hA2A2; mem0[3] = 16'hA3A3;
    mem1[0] = 16'hB0B0; mem1[1] = 16'hB1B1;
    push_frame(0, 2, 0, 8'd39, 1'b0);
    push_frame(1, 2, 0, 8'd39, 1'b0);
    push_frame(0, 2, 2, 8'd39, 1'b0);
    len0 = 4'd2; len1 = 4'd2; tx_drq = 1'b1; req = 2'b11;
    run_frame(2'b01, 2, 1'b1, 3, f, l, d);
    run_frame(2'b10, 2, 1'b1, 3, f, l, d);
    run_frame(2'b01, 2, 1'b1, 3, f, l, d);
    tick();
    req = 2'b00;

    // Single frame, done 100 cycles after the last word
    src_clr = 1'b1; tick(); src_clr = 1'b0;
    mem0[0] = 16'h0015; mem0[1] = 16'h1B00; mem0[2] = 16'h0085; mem0[3] = 16'hFF00;
    push_frame(0, 4, 0, 8'd71, 1'b0);
    len0 = 4'd4; req = 2'b01;
    run_frame(2'b01, 4, 1'b1, 100, f, l, d);
    chk("consecutive_words", l - f, 3);
    tick();
    req = 2'b00;
    chk("word_rd_count", rp0, 4);

    // Backpressure with tx_drq 1,0,0,1,...; a stray tx_done during FLAGS is ignored
    src_clr = 1'b1; tick(); src_clr = 1'b0;
    mem0[0] = 16'hC001; mem0[1] = 16'hC002; mem0[2] = 16'hC003; mem0[3] = 16'hC004;
    push_frame(0, 4, 0, 8'd71, 1'b0);
    len0 = 4'd4; req = 2'b01;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          tx_drq = pat[i % 4];
          tx_done = (i == 3);
          tick();
        end
        tx_done = 1'b0;
        tx_drq = 1'b1;
      end
      run_frame(2'b01, 4, 1'b1, 45, f, l, d);
    join
    tick();
    req = 2'b00;
    chk("bp_word_rd_count", rp0, 4);

    // Zero length: no writes, done+err two cycles after req seen in IDLE
    repeat (12) tick();
    push(K_DONE, {13'd0, 1'b1, 2'b01});
    len0 = 4'd0; req = 2'b01;
    rc = cyc;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done != 2'b00) begin seen = 1'b1; break; end
    end
    chk("zero_done_seen", {31'd0, seen}, 32'd1);
    chk("zero_len_latency", cyc - rc, 2);
    last_done_cyc = cyc;
    tick();
    req = 2'b00;

    // Timeout on requester 1
    src_clr = 1'b1; tick(); src_clr = 1'b0;
    mem1[0] = 16'h5A5A;
    push_frame(1, 1, 0, 8'd23, 1'b1);
    len1 = 4'd1; req = 2'b10;
    run_frame(2'b10, 1, 1'b0, 0, f, l, d);
    chk("timeout_latency", d - l, TIMEOUT + 1);
    @(negedge clk);
    chk("grant_cleared", {30'd0, grant}, 32'd0);
    tick();
    req = 2'b00;

    // Reset after 2 of 4 words, then a clean frame
    repeat (12) tick();
    src_clr = 1'b1; tick(); src_clr = 1'b0;
    mem0[0] = 16'hD001; mem0[1] = 16'hD002; mem0[2] = 16'hD003; mem0[3] = 16'hD004;
    push(K_LEN, 16'd71);
    for (int i = 0; i < FLAG_CNT; i++) push(K_FLG, 16'h00FF);
    push(K_FLG, 16'h007E);
    push(K_DAT, 16'hD001);
    push(K_DAT, 16'hD002);
    len0 = 4'd4; req = 2'b01;
    rc = 0;
    for (int k = 0; k < 40 && rc < 2; k++) begin
      @(negedge clk);
      if (dat_wr) rc++;
    end
    chk("pre_reset_words", rc, 2);
    tick();
    reset = 1'b1;
    #1;
    chk("mid_reset_outputs", {22'd0, grant, done, err, busy, len_wr, flag_wr, dat_wr, word_rd}, 32'd0);
    chk("no_pending_after_reset", exp_q.size(), 0);
    src_clr = 1'b1;
    tick();
    src_clr = 1'b0;
    tick();
    chk("held_reset_outputs", {22'd0, grant, done, err, busy, len_wr, flag_wr, dat_wr, word_rd}, 32'd0);
    push_frame(0, 4, 0, 8'd71, 1'b0);
    reset = 1'b0;
    run_frame(2'b01, 4, 1'b1, 5, f, l, d);
    tick();
    req = 2'b00;
    chk("post_reset_word_rd", rp0, 4);

    repeat (15) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
